// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : acq_sequencer
// Purpose  : Run-control for the ADC capture path. Programs the packetizer
//            packet-length register over an AXI4-Lite manager write port,
//            counts completed packets (last & ready), then writes zero to
//            the same register to stop forwarding after num_packets packets
//            or on abort.
// Ports    : aclk/aresetn        clock, async active-low reset
//            start/abort         run request / early stop request
//            packet_len          samples per packet (latched on start)
//            num_packets         packets per run (latched on start)
//            last/ready          packetizer tlast / upstream tready
//            busy/done/error     status (error is sticky until next start)
//            packets_done        packets counted in current/last run
//            m_axi_lite_*        AW/W/B channels of the config write port
// Options  : ACQ_SEQ_CONTINUOUS_EN - num_packets=0 runs until abort and
//            packets_done wraps at 16 bits.
// Revision : 1.0 - initial release
// ============================================================================
module acq_sequencer (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] packet_len,
   input  logic [15:0] num_packets,
   input  logic        last,
   input  logic        ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] packets_done,
   output logic [31:0] m_axi_lite_awaddr,
   output logic [2:0]  m_axi_lite_awprot,
   output logic        m_axi_lite_awvalid,
   input  logic        m_axi_lite_awready,
   output logic [31:0] m_axi_lite_wdata,
   output logic [3:0]  m_axi_lite_wstrb,
   output logic        m_axi_lite_wvalid,
   input  logic        m_axi_lite_wready,
   input  logic [1:0]  m_axi_lite_bresp,
   input  logic        m_axi_lite_bvalid,
   output logic        m_axi_lite_bready
);

   localparam logic [31:0] CFG_ADDR = 32'h0000_0200;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CFG_WR    = 3'd1,
      S_CFG_RESP  = 3'd2,
      S_RUN       = 3'd3,
      S_STOP_WR   = 3'd4,
      S_STOP_RESP = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_num;
   logic        r_abort;

   logic        w_start_ok;
   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_b_hs;
   logic        w_wr_done;
   logic        w_cap;
   logic        w_pkt;
   logic        w_last_pkt;
   logic [15:0] w_cnt_inc;

`ifdef ACQ_SEQ_CONTINUOUS_EN
   assign w_start_ok = start && (packet_len != 32'd0);
`else
   assign w_start_ok = start && (packet_len != 32'd0) && (num_packets != 16'd0);
`endif

   assign w_aw_hs   = m_axi_lite_awvalid & m_axi_lite_awready;
   assign w_w_hs    = m_axi_lite_wvalid  & m_axi_lite_wready;
   assign w_b_hs    = m_axi_lite_bready  & m_axi_lite_bvalid;
   // Both channels are finished after this edge when neither valid is left
   // waiting on its ready.
   assign w_wr_done = ~(m_axi_lite_awvalid & ~m_axi_lite_awready) &
                      ~(m_axi_lite_wvalid  & ~m_axi_lite_wready);

   // A zero packet target (continuous mode) never saturates the counter.
   assign w_cap      = (r_num != 16'd0) && (packets_done == r_num);
   assign w_pkt      = last & ready & ~w_cap;
   assign w_cnt_inc  = packets_done + 16'd1;
   assign w_last_pkt = w_pkt && (r_num != 16'd0) && (w_cnt_inc == r_num);

   assign m_axi_lite_awprot = 3'b000;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (w_start_ok) w_next = S_CFG_WR;
         S_CFG_WR:    if (w_wr_done) w_next = S_CFG_RESP;
         S_CFG_RESP:  if (w_b_hs) w_next = (m_axi_lite_bresp == 2'b00) ? S_RUN : S_IDLE;
         S_RUN:       if (w_last_pkt || r_abort || abort) w_next = S_STOP_WR;
         S_STOP_WR:   if (w_wr_done) w_next = S_STOP_RESP;
         S_STOP_RESP: if (w_b_hs) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state            <= S_IDLE;
         r_num              <= 16'd0;
         r_abort            <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         error              <= 1'b0;
         packets_done       <= 16'd0;
         m_axi_lite_awaddr  <= 32'd0;
         m_axi_lite_awvalid <= 1'b0;
         m_axi_lite_wdata   <= 32'd0;
         m_axi_lite_wstrb   <= 4'h0;
         m_axi_lite_wvalid  <= 1'b0;
         m_axi_lite_bready  <= 1'b0;
      end else begin
         r_state <= w_next;
         busy    <= (w_next != S_IDLE);
         done    <= (r_state == S_STOP_RESP) && w_b_hs && (m_axi_lite_bresp == 2'b00);

         // Write launch: both valids rise together, each drops on its own
         // handshake. wdata doubles as the latched packet length.
         if (r_state == S_IDLE && w_start_ok) begin
            r_num              <= num_packets;
            packets_done       <= 16'd0;
            error              <= 1'b0;
            r_abort            <= 1'b0;
            m_axi_lite_awaddr  <= CFG_ADDR;
            m_axi_lite_wdata   <= packet_len;
            m_axi_lite_wstrb   <= 4'hF;
            m_axi_lite_awvalid <= 1'b1;
            m_axi_lite_wvalid  <= 1'b1;
         end else if (r_state == S_RUN && w_next == S_STOP_WR) begin
            m_axi_lite_wdata   <= 32'd0;
            m_axi_lite_awvalid <= 1'b1;
            m_axi_lite_wvalid  <= 1'b1;
         end else begin
            if (w_aw_hs) m_axi_lite_awvalid <= 1'b0;
            if (w_w_hs)  m_axi_lite_wvalid  <= 1'b0;
         end

         if ((r_state == S_CFG_WR || r_state == S_STOP_WR) && w_wr_done)
            m_axi_lite_bready <= 1'b1;
         else if (w_b_hs)
            m_axi_lite_bready <= 1'b0;

         if (w_b_hs && m_axi_lite_bresp != 2'b00)
            error <= 1'b1;

         if ((r_state == S_CFG_WR || r_state == S_CFG_RESP || r_state == S_RUN) && abort)
            r_abort <= 1'b1;

         // The stop write stalls until the in-flight packet ends; that last
         // packet is still counted while in STOP_WR.
         if ((r_state == S_RUN || r_state == S_STOP_WR) && w_pkt)
            packets_done <= w_cnt_inc;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_acq_sequencer
// Purpose  : Directed self-checking bench for acq_sequencer. Expected config
//            write data is queued when a run is started and compared as the
//            AW/W handshakes appear on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acq_sequencer;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] packet_len = 32'd0;
   logic [15:0] num_packets = 16'd0;
   logic        last = 1'b0;
   logic        ready = 1'b0;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] packets_done;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready = 1'b1;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready = 1'b1;
   logic [1:0]  bresp = 2'b00;
   logic        bvalid = 1'b1;
   logic        bready;

   acq_sequencer dut (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .start              (start),
      .abort              (abort),
      .packet_len         (packet_len),
      .num_packets        (num_packets),
      .last               (last),
      .ready              (ready),
      .busy               (busy),
      .done               (done),
      .error              (error),
      .packets_done       (packets_done),
      .m_axi_lite_awaddr  (awaddr),
      .m_axi_lite_awprot  (awprot),
      .m_axi_lite_awvalid (awvalid),
      .m_axi_lite_awready (awready),
      .m_axi_lite_wdata   (wdata),
      .m_axi_lite_wstrb   (wstrb),
      .m_axi_lite_wvalid  (wvalid),
      .m_axi_lite_wready  (wready),
      .m_axi_lite_bresp   (bresp),
      .m_axi_lite_bvalid  (bvalid),
      .m_axi_lite_bready  (bready)
   );

   always #5 aclk = ~aclk;

   int n_chk = 0;
   int n_pass = 0;
   int aw_cnt = 0;
   int w_cnt = 0;
   int n_pushed = 0;
   int done_cnt = 0;
   int exp_done = 0;
   logic [31:0] aw_q[$];
   logic [31:0] w_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] mon_a;
   logic [31:0] mon_w;
   logic [31:0] mon_e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [31:0] d);
      exp_q.push_back(d);
      n_pushed++;
   endtask

   task automatic do_start(input logic [31:0] len, input logic [15:0] num);
      packet_len  = len;
      num_packets = num;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic pulse_pkt();
      last  = 1'b1;
      ready = 1'b1;
      tick();
      last  = 1'b0;
      ready = 1'b0;
      tick();
   endtask

   // Waits for busy to fall, then one more cycle so the done pulse is seen.
   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         tick();
      end
      check(tag, {31'd0, busy}, 32'd0);
      tick();
   endtask

   // Bus monitor: sampled on the falling edge, between driving and capture.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (awvalid && awready) begin
            aw_q.push_back(awaddr);
            aw_cnt++;
            check("awprot", {29'd0, awprot}, 32'd0);
         end
         if (wvalid && wready) begin
            w_q.push_back(wdata);
            w_cnt++;
            check("wstrb", {28'd0, wstrb}, 32'hF);
         end
         while (aw_q.size() > 0 && w_q.size() > 0) begin
            mon_a = aw_q.pop_front();
            mon_w = w_q.pop_front();
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("wr_addr", mon_a, 32'h0000_0200);
               check("wr_data", mon_w, mon_e);
            end
         end
         if (done) begin
            done_cnt++;
            check("done_busy", {31'd0, busy}, 32'd0);
         end
      end
   end

   initial begin
      // Reset values
      tick(2);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_pd", {16'd0, packets_done}, 32'd0);
      check("rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
      check("rst_awaddr", awaddr, 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_wstrb", {28'd0, wstrb}, 32'd0);
      aresetn = 1'b1;
      tick();

      // Basic run: 3 packets of length 8, bus always ready
      push_exp(32'd8);
      push_exp(32'd0);
      do_start(32'd8, 16'd3);
      check("t1_busy", {31'd0, busy}, 32'd1);
      check("t1_valids", {30'd0, awvalid, wvalid}, 32'd3);
      tick(2);
      last = 1'b1; ready = 1'b1;
      tick();
      last = 1'b0; ready = 1'b0;
      check("t1_pd_m1", {16'd0, packets_done}, 32'd1);
      tick();
      pulse_pkt();
      pulse_pkt();
      wait_idle("t1_idle");
      exp_done++;
      check("t1_pd", {16'd0, packets_done}, 32'd3);
      check("t1_err", {31'd0, error}, 32'd0);
      check("t1_done", done_cnt, exp_done);

      // Independent valid drop with delayed readies; RUN only after bvalid
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      push_exp(32'd5);
      push_exp(32'd0);
      do_start(32'd5, 16'd1);
      check("t2_valids", {30'd0, awvalid, wvalid}, 32'd3);
      wready = 1'b1;
      tick();
      wready = 1'b0;
      check("t2_w_drop", {30'd0, awvalid, wvalid}, 32'd2);
      tick(2);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      check("t2_aw_drop", {30'd0, awvalid, wvalid}, 32'd0);
      check("t2_bready", {31'd0, bready}, 32'd1);
      pulse_pkt();
      check("t2_no_count", {16'd0, packets_done}, 32'd0);
      check("t2_wait_b", {30'd0, busy, bready}, 32'd3);
      bvalid = 1'b1;
      tick();
      awready = 1'b1; wready = 1'b1;
      tick();
      pulse_pkt();
      wait_idle("t2_idle");
      exp_done++;
      check("t2_pd", {16'd0, packets_done}, 32'd1);
      check("t2_done", done_cnt, exp_done);

      // Abort after packet 1 with the stop write stalled until a last
      push_exp(32'd16);
      push_exp(32'd0);
      do_start(32'd16, 16'd5);
      tick(2);
      pulse_pkt();
      awready = 1'b0; wready = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t3_stop_aw", {31'd0, awvalid}, 32'd1);
      tick(5);
      check("t3_stall", {30'd0, awvalid, busy}, 32'd3);
      check("t3_pd1", {16'd0, packets_done}, 32'd1);
      last = 1'b1; ready = 1'b1; awready = 1'b1; wready = 1'b1;
      tick();
      last = 1'b0; ready = 1'b0;
      check("t3_pd2_now", {16'd0, packets_done}, 32'd2);
      wait_idle("t3_idle");
      exp_done++;
      check("t3_pd", {16'd0, packets_done}, 32'd2);
      check("t3_done", done_cnt, exp_done);

      // SLVERR on config write
      bresp = 2'b10;
      push_exp(32'd7);
      do_start(32'd7, 16'd2);
      tick(2);
      check("t4_idle", {31'd0, busy}, 32'd0);
      check("t4_err", {31'd0, error}, 32'd1);
      tick(3);
      check("t4_no_done", done_cnt, exp_done);
      check("t4_no_stop", aw_cnt, n_pushed);
      bresp = 2'b00;
      push_exp(32'd9);
      push_exp(32'd0);
      do_start(32'd9, 16'd1);
      check("t4_err_clr", {31'd0, error}, 32'd0);
      tick(2);
      pulse_pkt();
      wait_idle("t4_idle2");
      exp_done++;
      check("t4_done", done_cnt, exp_done);

      // Ignored starts: zero length, zero count, and while busy
      do_start(32'd0, 16'd4);
      tick(3);
      check("t5_len0", {30'd0, busy, awvalid}, 32'd0);
      check("t5_len0_bus", aw_cnt, n_pushed);
      check("t5_pd_hold", {16'd0, packets_done}, 32'd1);
`ifndef ACQ_SEQ_CONTINUOUS_EN
      do_start(32'd3, 16'd0);
      tick(3);
      check("t5_num0", {30'd0, busy, awvalid}, 32'd0);
      check("t5_num0_bus", aw_cnt, n_pushed);
`endif
      push_exp(32'd11);
      push_exp(32'd0);
      do_start(32'd11, 16'd2);
      tick(2);
      pulse_pkt();
      do_start(32'd99, 16'd1);
      check("t5_busy_start", {31'd0, busy}, 32'd1);
      check("t5_busy_pd", {16'd0, packets_done}, 32'd1);
      pulse_pkt();
      wait_idle("t5_idle");
      exp_done++;
      check("t5_pd", {16'd0, packets_done}, 32'd2);
      check("t5_done", done_cnt, exp_done);
      check("t5_bus", aw_cnt, n_pushed - exp_q.size());

`ifdef ACQ_SEQ_CONTINUOUS_EN
      // Continuous: 70000 packets, wrap, only abort ends the run
      push_exp(32'd4);
      push_exp(32'd0);
      do_start(32'd4, 16'd0);
      tick(2);
      last = 1'b1; ready = 1'b1;
      tick(69999);
      check("t7_still_busy", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0; last = 1'b0; ready = 1'b0;
      wait_idle("t7_idle");
      exp_done++;
      check("t7_pd", {16'd0, packets_done}, 32'd4464);
      check("t7_done", done_cnt, exp_done);
`endif

      // Asynchronous reset during CFG_RESP, then a clean run
      bvalid = 1'b0;
      push_exp(32'd13);
      do_start(32'd13, 16'd1);
      tick();
      check("t6_bready", {31'd0, bready}, 32'd1);
      #2 aresetn = 1'b0;
      #1;
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
      check("t6_addr_data", awaddr | wdata, 32'd0);
      check("t6_pd", {16'd0, packets_done}, 32'd0);
      tick();
      aresetn = 1'b1;
      bvalid = 1'b1;
      push_exp(32'd21);
      push_exp(32'd0);
      do_start(32'd21, 16'd1);
      tick(2);
      pulse_pkt();
      wait_idle("t6_idle");
      exp_done++;
      check("t6_pd_run", {16'd0, packets_done}, 32'd1);
      check("t6_done", done_cnt, exp_done);

      // Global bookkeeping
      tick(2);
      check("exp_empty", exp_q.size(), 32'd0);
      check("aw_total", aw_cnt, n_pushed);
      check("w_total", w_cnt, n_pushed);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
